// File: rtl/satir_bellek_denetleyici_pkg.sv
// Shared widths and request record for the line RAM controller.
// Optional statistics ports are enabled with SATIR_BELLEK_ISTATISTIK_EN.
package satir_bellek_denetleyici_pkg;

    localparam int ADRES_BIT       = 32;
    localparam int VO_VERI_BIT     = 128;
    localparam int SATIR_OFSET_BIT = 7;

    typedef enum logic {
        ISTEK_OKU = 1'b0,
        ISTEK_YAZ = 1'b1
    } istek_tip_t;

    typedef struct packed {
        istek_tip_t             tip;
        logic [ADRES_BIT-1:0]   adres;
        logic [VO_VERI_BIT-1:0] veri;
    } istek_t;

endpackage

// File: rtl/satir_bellek_denetleyici_istek_fifo.sv
// In-order request queue feeding the single-port line array.
// Storage is not reset; only pointers and count are.
module satir_bellek_denetleyici_istek_fifo
    import satir_bellek_denetleyici_pkg::*;
#(
    parameter  int DERINLIK = 4,
    localparam int PW       = $clog2(DERINLIK),
    localparam int SW       = PW + 1
) (
    input  logic          clk_g,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  istek_t        giris,
    output istek_t        bas,
    output logic          full,
    output logic          empty,
    output logic [SW-1:0] count
);

    istek_t        mem [DERINLIK];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == SW'(DERINLIK));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign bas     = mem[rd_ptr];

    always_ff @(posedge clk_g) begin
        if (do_push)
            mem[wr_ptr] <= giris;
    end

    always_ff @(posedge clk_g or posedge resetn) begin
        if (resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + SW'(1);
                2'b01:   count <= count - SW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/satir_bellek_denetleyici.sv
// Line RAM controller: queues requests, serialises them onto the array.
// Define SATIR_BELLEK_ISTATISTIK_EN to add accepted read/write counters.
module satir_bellek_denetleyici
    import satir_bellek_denetleyici_pkg::*;
#(
    parameter int SATIR_SAYISI  = 256,
    parameter int FIFO_DERINLIK = 4,
    parameter int OKUMA_GECIKME = 2
) (
    input  logic                   clk_g,
    input  logic                   resetn,
    input  logic [ADRES_BIT-1:0]   ram_adres_g,
    input  logic                   ram_oku_gecerli_g,
    input  logic [VO_VERI_BIT-1:0] ram_yaz_veri_g,
    input  logic                   ram_yaz_gecerli_g,
    output logic [VO_VERI_BIT-1:0] ram_oku_veri_c,
    output logic [ADRES_BIT-1:0]   ram_oku_adres_c,
    output logic                   ram_oku_gecerli_c,
    output logic                   ram_mesgul_c,
    output logic                   hata_c
`ifdef SATIR_BELLEK_ISTATISTIK_EN
    ,
    output logic [31:0]            okuma_sayisi_c,
    output logic [31:0]            yazma_sayisi_c
`endif
);

    localparam int SW = $clog2(FIFO_DERINLIK) + 1;
    localparam int IW = $clog2(SATIR_SAYISI);
    localparam int L  = OKUMA_GECIKME;

    istek_t        giris;
    istek_t        bas;
    logic          push;
    logic          pop;
    logic          dolu;
    logic          bos;
    logic [SW-1:0] sayi;
    logic          istek_var;
    logic          bas_oku;
    logic [IW-1:0] satir;

    logic [VO_VERI_BIT-1:0] dizi   [SATIR_SAYISI];
    logic                   boru_v [L];
    logic [ADRES_BIT-1:0]   boru_a [L];
    logic [VO_VERI_BIT-1:0] boru_d [L];

    assign istek_var    = ram_oku_gecerli_g || ram_yaz_gecerli_g;
    assign push         = istek_var && !dolu;
    assign ram_mesgul_c = (sayi == SW'(FIFO_DERINLIK));

    // A write wins when both strobes arrive together.
    assign giris.tip   = ram_yaz_gecerli_g ? ISTEK_YAZ : ISTEK_OKU;
    assign giris.adres = ram_adres_g;
    assign giris.veri  = ram_yaz_veri_g;

    assign pop     = !bos;
    assign bas_oku = pop && (bas.tip == ISTEK_OKU);
    assign satir   = bas.adres[SATIR_OFSET_BIT +: IW];

    satir_bellek_denetleyici_istek_fifo #(
        .DERINLIK (FIFO_DERINLIK)
    ) u_fifo (
        .clk_g  (clk_g),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .giris  (giris),
        .bas    (bas),
        .full   (dolu),
        .empty  (bos),
        .count  (sayi)
    );

    always_ff @(posedge clk_g) begin
        if (pop && bas.tip == ISTEK_YAZ)
            dizi[satir] <= bas.veri;
    end

    always_ff @(posedge clk_g or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < L; i++) begin
                boru_v[i] <= 1'b0;
                boru_a[i] <= '0;
                boru_d[i] <= '0;
            end
        end else begin
            boru_v[0] <= bas_oku;
            if (bas_oku) begin
                boru_a[0] <= bas.adres;
                boru_d[0] <= dizi[satir];
            end
            for (int i = 1; i < L; i++) begin
                boru_v[i] <= boru_v[i-1];
                if (boru_v[i-1]) begin
                    boru_a[i] <= boru_a[i-1];
                    boru_d[i] <= boru_d[i-1];
                end
            end
        end
    end

    assign ram_oku_gecerli_c = boru_v[L-1];
    assign ram_oku_adres_c   = boru_a[L-1];
    assign ram_oku_veri_c    = boru_d[L-1];

    always_ff @(posedge clk_g or posedge resetn) begin
        if (resetn)
            hata_c <= 1'b0;
        else if ((istek_var && dolu) ||
                 (ram_oku_gecerli_g && ram_yaz_gecerli_g))
            hata_c <= 1'b1;
    end

`ifdef SATIR_BELLEK_ISTATISTIK_EN
    logic okuma_kabul;

    assign okuma_kabul = ram_oku_gecerli_g && !ram_yaz_gecerli_g && !dolu;

    always_ff @(posedge clk_g or posedge resetn) begin
        if (resetn) begin
            okuma_sayisi_c <= '0;
            yazma_sayisi_c <= '0;
        end else begin
            if (okuma_kabul)
                okuma_sayisi_c <= okuma_sayisi_c + 32'd1;
            if (ram_yaz_gecerli_g && !dolu)
                yazma_sayisi_c <= yazma_sayisi_c + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_satir_bellek_denetleyici.sv
// Bench for the line RAM controller: directed literals plus random traffic
// checked every cycle against a queue-based reference model.
module tb_satir_bellek_denetleyici;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int LINES = 256;

    logic         clk_g = 1'b0;
    logic         resetn = 1'b1;
    logic [31:0]  ram_adres_g = '0;
    logic         ram_oku_gecerli_g = 1'b0;
    logic [127:0] ram_yaz_veri_g = '0;
    logic         ram_yaz_gecerli_g = 1'b0;
    logic [127:0] ram_oku_veri_c;
    logic [31:0]  ram_oku_adres_c;
    logic         ram_oku_gecerli_c;
    logic         ram_mesgul_c;
    logic         hata_c;
`ifdef SATIR_BELLEK_ISTATISTIK_EN
    logic [31:0]  okuma_sayisi_c;
    logic [31:0]  yazma_sayisi_c;
`endif

    satir_bellek_denetleyici dut (
        .clk_g             (clk_g),
        .resetn            (resetn),
        .ram_adres_g       (ram_adres_g),
        .ram_oku_gecerli_g (ram_oku_gecerli_g),
        .ram_yaz_veri_g    (ram_yaz_veri_g),
        .ram_yaz_gecerli_g (ram_yaz_gecerli_g),
        .ram_oku_veri_c    (ram_oku_veri_c),
        .ram_oku_adres_c   (ram_oku_adres_c),
        .ram_oku_gecerli_c (ram_oku_gecerli_c),
        .ram_mesgul_c      (ram_mesgul_c),
        .hata_c            (hata_c)
`ifdef SATIR_BELLEK_ISTATISTIK_EN
        ,
        .okuma_sayisi_c    (okuma_sayisi_c),
        .yazma_sayisi_c    (yazma_sayisi_c)
`endif
    );

    always #5 clk_g = ~clk_g;

    typedef struct {
        bit           yaz;
        logic [31:0]  a;
        logic [127:0] d;
    } mreq_t;

    typedef struct {
        int           due;
        logic [31:0]  a;
        logic [127:0] d;
        bit           known;
    } mexp_t;

    mreq_t        q[$];
    mexp_t        eq[$];
    logic [127:0] mmem [LINES];
    bit           mknown [LINES];
    bit           m_hata = 1'b0;
    int unsigned  m_ok = 0;
    int unsigned  m_yz = 0;
    int           edge_cnt = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 7) % LINES);
    endfunction

    // Reference model: one queue pop per edge, result visible LAT-1 edges later.
    always @(posedge clk_g) begin
        mreq_t h;
        int    li;
        bit    busy;
        edge_cnt++;
        if (resetn) begin
            q.delete();
            eq.delete();
            m_hata = 1'b0;
            m_ok   = 0;
            m_yz   = 0;
        end else begin
            busy = (q.size() == DEPTH);
            if ((ram_oku_gecerli_g || ram_yaz_gecerli_g) && busy)
                m_hata = 1'b1;
            if (ram_oku_gecerli_g && ram_yaz_gecerli_g)
                m_hata = 1'b1;
            if (q.size() > 0) begin
                h  = q.pop_front();
                li = line_of(h.a);
                if (h.yaz) begin
                    mmem[li]   = h.d;
                    mknown[li] = 1'b1;
                end else begin
                    eq.push_back('{due: edge_cnt + LAT - 1, a: h.a,
                                   d: mmem[li], known: mknown[li]});
                end
            end
            if (!busy && ram_yaz_gecerli_g) begin
                q.push_back('{yaz: 1'b1, a: ram_adres_g, d: ram_yaz_veri_g});
                m_yz++;
            end else if (!busy && ram_oku_gecerli_g) begin
                q.push_back('{yaz: 1'b0, a: ram_adres_g, d: '0});
                m_ok++;
            end
        end
    end

    always @(negedge clk_g) begin
        bit    ev;
        mexp_t e;
        #2;
        if (!resetn) begin
            while (eq.size() > 0 && eq[0].due < edge_cnt)
                void'(eq.pop_front());
            ev = (eq.size() > 0) && (eq[0].due == edge_cnt);
            chk("gecerli", ram_oku_gecerli_c, ev);
            if (ev) begin
                e = eq.pop_front();
                chk("oku_adres", ram_oku_adres_c, e.a);
                if (e.known)
                    chk("oku_veri", ram_oku_veri_c, e.d);
            end
            chk("mesgul", ram_mesgul_c, q.size() == DEPTH);
            chk("hata", hata_c, m_hata);
`ifdef SATIR_BELLEK_ISTATISTIK_EN
            chk("okuma_sayisi", okuma_sayisi_c, m_ok);
            chk("yazma_sayisi", yazma_sayisi_c, m_yz);
`endif
        end
    end

    task automatic cyc_drive(input bit o, input bit y,
                             input logic [31:0] a, input logic [127:0] d);
        @(negedge clk_g);
        ram_oku_gecerli_g = o;
        ram_yaz_gecerli_g = y;
        ram_adres_g       = a;
        ram_yaz_veri_g    = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, 1'b0, '0, '0);
    endtask

    // Read with the queue idle: valid exactly three cycles after accept.
    task automatic rd_lit(input logic [31:0] a, input logic [127:0] d);
        cyc_drive(1'b1, 1'b0, a, '0);
        for (int i = 1; i <= 3; i++) begin
            cyc_drive(1'b0, 1'b0, '0, '0);
            #1;
            if (i < 3) begin
                chk("lit_gecerli_erken", ram_oku_gecerli_c, 1'b0);
            end else begin
                chk("lit_gecerli", ram_oku_gecerli_c, 1'b1);
                chk("lit_veri", ram_oku_veri_c, d);
                chk("lit_adres", ram_oku_adres_c, a);
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gecerli"}, ram_oku_gecerli_c, 1'b0);
        chk({nm, "_veri"}, ram_oku_veri_c, '0);
        chk({nm, "_adres"}, ram_oku_adres_c, '0);
        chk({nm, "_mesgul"}, ram_mesgul_c, 1'b0);
        chk({nm, "_hata"}, hata_c, 1'b0);
`ifdef SATIR_BELLEK_ISTATISTIK_EN
        chk({nm, "_okuma_sayisi"}, okuma_sayisi_c, '0);
        chk({nm, "_yazma_sayisi"}, yazma_sayisi_c, '0);
`endif
    endtask

    initial begin
        logic [127:0] a5;
        logic [127:0] x_old;
        logic [127:0] x_new;
        logic [127:0] z;
        logic [31:0]  ra;
        a5    = {16{8'hA5}};
        x_old = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        x_new = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        z     = 128'h0F0F_0F0F_0000_0000_FFFF_FFFF_1234_5678;

        repeat (3) @(negedge clk_g);
        #1 chk_all_zero("reset");
        @(negedge clk_g);
        resetn = 1'b0;
        idle(2);

        cyc_drive(1'b0, 1'b1, 32'h80, a5);
        idle(2);
        rd_lit(32'h80, a5);
        rd_lit(32'h85, a5);

        cyc_drive(1'b0, 1'b1, 32'(3 << 7), x_old);
        idle(2);
        cyc_drive(1'b0, 1'b1, 32'(3 << 7), x_new);
        rd_lit(32'(3 << 7), x_new);

        cyc_drive(1'b0, 1'b1, 32'(256 << 7), 128'h1);
        idle(2);
        rd_lit(32'h0, 128'h1);

        #1 chk("hata_temiz", hata_c, 1'b0);
        cyc_drive(1'b1, 1'b1, 32'(5 << 7), z);
        idle(1);
        #1 chk("hata_ikili", hata_c, 1'b1);
        idle(1);
        rd_lit(32'(5 << 7), z);

        cyc_drive(1'b1, 1'b0, 32'h100, '0);
        cyc_drive(1'b1, 1'b0, 32'h180, '0);
        @(negedge clk_g);
        resetn            = 1'b1;
        ram_oku_gecerli_g = 1'b0;
        ram_yaz_gecerli_g = 1'b0;
        #1 chk_all_zero("async_reset");
        repeat (2) @(negedge clk_g);
        resetn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            #1 chk("reset_sonrasi_gecerli", ram_oku_gecerli_c, 1'b0);
        end

        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0)
                ra[14:7] = 8'($urandom_range(0, 7));
            cyc_drive($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 30,
                      ra, {$urandom, $urandom, $urandom, $urandom});
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
